// File: rtl/udp_tx_stream_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream UDP TX payload stream
// between NUM_SRC sources, with a per-source enable mask and packet counters.
module udp_tx_stream_arbiter #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned DATA_W  = 64
) (
    input  logic                            aclk,
    input  logic                            areset,
    input  logic [NUM_SRC*DATA_W-1:0]       s_axis_tdata,
    input  logic [NUM_SRC*(DATA_W/8)-1:0]   s_axis_tkeep,
    input  logic [NUM_SRC-1:0]              s_axis_tvalid,
    input  logic [NUM_SRC-1:0]              s_axis_tlast,
    output logic [NUM_SRC-1:0]              s_axis_tready,
    output logic [DATA_W-1:0]               m_axis_tdata,
    output logic [DATA_W/8-1:0]             m_axis_tkeep,
    output logic                            m_axis_tvalid,
    output logic                            m_axis_tlast,
    input  logic                            m_axis_tready,
    input  logic                            reg_wr_en,
    input  logic                            reg_rd_en,
    input  logic [7:0]                      reg_addr,
    input  logic [31:0]                     reg_wdata,
    output logic [31:0]                     reg_rdata,
    output logic                            reg_ack
);

    localparam int unsigned KEEP_W  = DATA_W / 8;
    localparam int unsigned GRANT_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [GRANT_W-1:0]       grant;
    logic [GRANT_W-1:0]       last_grant;
    logic [GRANT_W-1:0]       pick;
    logic [GRANT_W-1:0]       idx;
    logic                     found;
    logic [NUM_SRC-1:0]       en_mask;
    logic [NUM_SRC-1:0]       req;
    logic [NUM_SRC-1:0][31:0] pkt_cnt;
    logic                     pkt_done;
    logic                     cnt_clr;
    logic [31:0]              rd_value;
    logic [2:0]               grant_view;
    logic                     unused_wdata;

    assign req          = s_axis_tvalid & en_mask;
    assign cnt_clr      = reg_wr_en && (reg_addr == 8'd4);
    assign grant_view   = 3'(grant);
    assign unused_wdata = &{1'b0, reg_wdata};

    // Round-robin search starting one past the previous winner
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_SRC; k++) begin
            idx = GRANT_W'((32'(last_grant) + k) % NUM_SRC);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Next state and the combinational pass-through of the granted source
    always_comb begin
        state_next    = state;
        pkt_done      = 1'b0;
        s_axis_tready = '0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        case (state)
            IDLE: begin
                if (found) state_next = BUSY;
            end
            BUSY: begin
                m_axis_tdata         = s_axis_tdata[32'(grant)*DATA_W +: DATA_W];
                m_axis_tkeep         = s_axis_tkeep[32'(grant)*KEEP_W +: KEEP_W];
                m_axis_tvalid        = s_axis_tvalid[grant];
                m_axis_tlast         = s_axis_tlast[grant];
                s_axis_tready[grant] = m_axis_tready;
                if (s_axis_tvalid[grant] && s_axis_tlast[grant] && m_axis_tready) begin
                    pkt_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GRANT_W'(NUM_SRC - 1);
        end else begin
            state <= state_next;
            if (state == IDLE && found) begin
                grant      <= pick;
                last_grant <= pick;
            end
        end
    end

    // Enable mask and packet counters; a clear beats a same-cycle increment
    always_ff @(posedge aclk) begin
        if (areset) begin
            en_mask <= '1;
            pkt_cnt <= '0;
        end else begin
            if (reg_wr_en && reg_addr == 8'd0) en_mask <= reg_wdata[NUM_SRC-1:0];
            if (cnt_clr) pkt_cnt <= '0;
            else if (pkt_done) pkt_cnt[grant] <= pkt_cnt[grant] + 32'd1;
        end
    end

    always_comb begin
        rd_value = 32'hFEED_FACE;
        if (reg_addr == 8'd0) rd_value = 32'(en_mask);
        else if (reg_addr == 8'd1) rd_value = {23'd0, state == BUSY, 5'd0, grant_view};
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (reg_addr == 8'(8 + i)) rd_value = pkt_cnt[GRANT_W'(i)];
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            reg_ack   <= 1'b0;
            reg_rdata <= 32'hDEAD_BEEF;
        end else begin
            reg_ack <= reg_rd_en;
            if (reg_rd_en) reg_rdata <= rd_value;
        end
    end

endmodule
